// File: rtl/cas_pkg.sv
// Shared constants and types for the cassette recorder.
package cas_pkg;

  // Default thresholds, counted in emulated-CPU clock enables.
  // At 500 baud a bit cell is ~3548 enables; the split sits at 0.75 of a cell,
  // the gap at 1.5 cells.
  localparam int DEF_MIN_INT = 200;
  localparam int DEF_SPLIT   = 2662;
  localparam int DEF_GAP_MAX = 5322;

  // Interval counter width; it saturates at all-ones.
  localparam int CNT_W = 16;

  // First byte of every Level II block after the zero leader.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } cas_state_e;

endpackage

// File: rtl/cas_pulse_decoder.sv
// Cassette pulse decoder: rising-edge detect on the port FF output level,
// cpu_ce-based interval timing, and data/clock/timeout classification.
module cas_pulse_decoder
  import cas_pkg::*;
#(
  parameter int MIN_INT = DEF_MIN_INT,
  parameter int SPLIT   = DEF_SPLIT,
  parameter int GAP_MAX = DEF_GAP_MAX
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cpu_ce,
  input  logic [1:0] cas_out,
  input  logic       inhibit,    // upload in progress: pulses are ignored
  input  logic       clear,      // recording cleared: drop the pending data flag
  output logic       bit_valid,  // one cycle per decoded bit
  output logic       bit_value,
  output logic       timeout     // one cycle when a gap ends the current block
);

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_INT);
  localparam logic [CNT_W-1:0] SPLIT_C = CNT_W'(SPLIT);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [1:0]       prev_out;
  logic [CNT_W-1:0] cnt;
  logic             one_flag;

  logic pulse;
  logic is_data;
  logic is_clock;
  logic is_gap;
  logic restart;
  logic gap_reached;

  // Classify the current pulse against the running interval.
  // The interval is measured from the last bit-cell clock (or gap), so the
  // half-cell data pulse of a '1' never restarts the cell timing and the
  // following clock still lands in the clock window.
  always_comb begin
    pulse       = (cas_out != 2'b00) && (prev_out == 2'b00) && !inhibit;
    is_data     = (cnt >= MIN_C) && (cnt < SPLIT_C);
    is_clock    = (cnt >= SPLIT_C) && (cnt <= GAP_C);
    is_gap      = (cnt > GAP_C);
    restart     = pulse && (is_clock || is_gap);
    gap_reached = cpu_ce && (cnt == GAP_C) && !restart;
  end

  // Previous output level for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) prev_out <= 2'b00;
    else          prev_out <= cas_out;
  end

  // Interval counter: counts CPU enables, saturates, restarts on a cell boundary.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                       cnt <= '0;
    else if (restart)                   cnt <= '0;
    else if (cpu_ce && cnt != CNT_SAT)  cnt <= cnt + CNT_W'(1);
  end

  // Data flag and registered bit/timeout events.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      one_flag  <= 1'b0;
      bit_valid <= 1'b0;
      bit_value <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      bit_valid <= pulse && is_clock;
      timeout   <= (pulse && is_gap) || gap_reached;
      if (pulse && is_clock) bit_value <= one_flag;
      if (clear || restart)        one_flag <= 1'b0;
      else if (pulse && is_data)   one_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/cas_recorder.sv
// Cassette recorder: decodes CSAVE output into bytes, stores them in a byte
// RAM and serves the image to the HPS over the ioctl upload port.
module cas_recorder
  import cas_pkg::*;
#(
  parameter int AW      = 16,
  parameter int MIN_INT = DEF_MIN_INT,
  parameter int SPLIT   = DEF_SPLIT,
  parameter int GAP_MAX = DEF_GAP_MAX
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_ce,
  input  logic [1:0]    cas_out,
  input  logic          rec_clear,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic [AW:0]   rec_len,
  output logic          rec_active,
  output logic          overflow
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

  logic       bit_valid;
  logic       bit_value;
  logic       timeout;

  cas_state_e state;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic [7:0] shreg_next;
  logic       sync_hit;
  logic       store_req;
  logic       full;
  logic       do_write;

  logic [7:0] mem [DEPTH];
  logic [7:0] ram_q;
  logic       rd_ok;

  cas_pulse_decoder #(
    .MIN_INT (MIN_INT),
    .SPLIT   (SPLIT),
    .GAP_MAX (GAP_MAX)
  ) u_dec (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .cpu_ce    (cpu_ce),
    .cas_out   (cas_out),
    .inhibit   (ioctl_upload),
    .clear     (rec_clear),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .timeout   (timeout)
  );

  // Byte framing decisions for the bit arriving this cycle.
  always_comb begin
    shreg_next = {shreg[6:0], bit_value};
    sync_hit   = (shreg_next == SYNC_BYTE);
    store_req  = bit_valid && !ioctl_upload &&
                 (((state == HUNT) && sync_hit) ||
                  ((state == SYNC) && (bitcnt == 3'd7)));
    full       = (rec_len == CAPACITY);
    do_write   = store_req && !rec_clear && !full;
  end

  // Framer: hunt for the sync byte, then cut the bit stream into bytes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= HUNT;
      shreg  <= '0;
      bitcnt <= '0;
    end else if (rec_clear || ioctl_upload) begin
      state <= HUNT;
    end else if (timeout) begin
      state <= HUNT;
      shreg <= '0;
    end else if (bit_valid) begin
      shreg <= shreg_next;
      if (state == HUNT) begin
        if (sync_hit) begin
          state  <= SYNC;
          bitcnt <= '0;
        end
      end else begin
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

  // Block activity flag trails the framer state by one cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rec_active <= 1'b0;
    else          rec_active <= (state == SYNC);
  end

  // Length / overflow bookkeeping; a clear in the same cycle as a store wins.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rec_len  <= '0;
      overflow <= 1'b0;
    end else if (rec_clear) begin
      rec_len  <= '0;
      overflow <= 1'b0;
    end else if (store_req) begin
      if (full) overflow <= 1'b1;
      else      rec_len  <= rec_len + (AW+1)'(1);
    end
  end

  // RAM write port; the write pointer is simply the low bits of the length.
  always_ff @(posedge clk_sys) begin
    if (do_write) mem[rec_len[AW-1:0]] <= shreg_next;
  end

  // RAM read port, kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk_sys) begin
    if (ioctl_rd) ram_q <= mem[ioctl_addr];
  end

  // Address validity captured alongside the read; both hold between strobes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)      rd_ok <= 1'b0;
    else if (ioctl_rd) rd_ok <= ({1'b0, ioctl_addr} < rec_len);
  end

  // Reads past the recorded length return zero.
  assign ioctl_din = rd_ok ? ram_q : 8'h00;

endmodule

// File: tb/tb_cas_recorder.sv
// Directed bench for cas_recorder. Thresholds are scaled down (cell of ~40
// enables) so whole blocks fit in a short run; a second AW=4 instance shares
// the stimulus to exercise the full/overflow path.
module tb_cas_recorder;

  localparam int MIN_T   = 4;
  localparam int SPLIT_T = 30;
  localparam int GAP_T   = 60;

  logic        clk_sys      = 1'b0;
  logic        reset_n      = 1'b1;
  logic        cpu_ce       = 1'b0;
  logic [1:0]  cas_out      = 2'b00;
  logic        rec_clear    = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd     = 1'b0;
  logic [15:0] ioctl_addr   = '0;

  logic [7:0]  din_a, din_b;
  logic [16:0] len_a;
  logic [4:0]  len_b;
  logic        act_a, act_b, ovf_a, ovf_b;

  int checks   = 0;
  int failures = 0;

  cas_recorder #(.AW(16), .MIN_INT(MIN_T), .SPLIT(SPLIT_T), .GAP_MAX(GAP_T)) u_dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .cpu_ce       (cpu_ce),
    .cas_out      (cas_out),
    .rec_clear    (rec_clear),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (din_a),
    .rec_len      (len_a),
    .rec_active   (act_a),
    .overflow     (ovf_a)
  );

  cas_recorder #(.AW(4), .MIN_INT(MIN_T), .SPLIT(SPLIT_T), .GAP_MAX(GAP_T)) u_small (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .cpu_ce       (cpu_ce),
    .cas_out      (cas_out),
    .rec_clear    (rec_clear),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr[3:0]),
    .ioctl_din    (din_b),
    .rec_len      (len_b),
    .rec_active   (act_b),
    .overflow     (ovf_b)
  );

  always #5 clk_sys = ~clk_sys;

  // CPU enable every second clk_sys cycle.
  initial forever begin
    @(negedge clk_sys);
    cpu_ce = ~cpu_ce;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic ce_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      while (cpu_ce !== 1'b1) @(posedge clk_sys);
    end
  endtask

  task automatic pulse(input logic [1:0] v);
    @(negedge clk_sys) cas_out = v;
    @(negedge clk_sys) cas_out = 2'b00;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    int pre;
    pre = 0;
    if (glitch) begin
      ce_wait(2);
      pulse(2'b11);
      pre = 3;
    end
    if (b) begin
      ce_wait(20 - pre);
      pulse(2'b10);
      ce_wait(20);
      pulse(2'b01);
    end else begin
      ce_wait(41 - pre);
      pulse(2'b01);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic glitch);
    for (int i = 7; i >= 0; i--) send_bit(v[i], glitch);
  endtask

  // Gap pulse to start clean, then zero leader bytes.
  task automatic start_block(input int leader);
    ce_wait(70);
    pulse(2'b01);
    for (int i = 0; i < leader; i++) send_byte(8'h00, 1'b0);
  endtask

  task automatic do_read(input logic [15:0] a);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd   = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk_sys) rec_clear = 1'b1;
    @(negedge clk_sys) rec_clear = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++; if (len_a !== 17'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", len_a); end
    checks++; if (act_a !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", act_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf_a); end
    checks++; if (din_a !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", din_a); end
    checks++; if (len_b !== 5'd0 || ovf_b !== 1'b0) begin failures++; $display("FAIL reset_small got=%0d/%b exp=0/0", len_b, ovf_b); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_basic();
    start_block(2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h7F, 1'b0);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd3) begin failures++; $display("FAIL basic_len got=%0d exp=3", len_a); end
    checks++; if (len_b !== 5'd3) begin failures++; $display("FAIL basic_len_small got=%0d exp=3", len_b); end
    checks++; if (act_a !== 1'b1) begin failures++; $display("FAIL basic_active got=%b exp=1", act_a); end
  endtask

  task automatic test_timeout_append();
    int k;
    k = 0;
    while (act_a === 1'b1 && k < 200) begin
      ce_wait(1);
      #1;
      k++;
    end
    checks++; if (act_a !== 1'b0) begin failures++; $display("FAIL timeout_fall got=%b exp=0", act_a); end
    checks++; if (k < 55 || k > 64) begin failures++; $display("FAIL timeout_when got=%0d exp=55..64", k); end
    start_block(1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd5) begin failures++; $display("FAIL append_len got=%0d exp=5", len_a); end
  endtask

  task automatic test_upload_read();
    logic [7:0] exp_rd [6];
    exp_rd = '{8'hA5, 8'h42, 8'h7F, 8'hA5, 8'h11, 8'h00};
    ioctl_upload = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_read(16'(i));
      checks++; if (din_a !== exp_rd[i]) begin failures++; $display("FAIL upload_addr%0d got=%h exp=%h", i, din_a, exp_rd[i]); end
    end
    do_read(16'd4);
    checks++; if (din_b !== 8'h11) begin failures++; $display("FAIL upload_small got=%h exp=11", din_b); end
    do_read(16'd1);
    repeat (5) @(negedge clk_sys);
    checks++; if (din_a !== 8'h42) begin failures++; $display("FAIL upload_hold got=%h exp=42", din_a); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_glitch();
    start_block(1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd7) begin failures++; $display("FAIL glitch_len got=%0d exp=7", len_a); end
    ioctl_upload = 1'b1;
    do_read(16'd5);
    checks++; if (din_a !== 8'hA5) begin failures++; $display("FAIL glitch_addr5 got=%h exp=a5", din_a); end
    do_read(16'd6);
    checks++; if (din_a !== 8'h3C) begin failures++; $display("FAIL glitch_addr6 got=%h exp=3c", din_a); end
    do_read(16'd7);
    checks++; if (din_a !== 8'h00) begin failures++; $display("FAIL glitch_addr7 got=%h exp=00", din_a); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_upload_midblock();
    start_block(1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h81, 1'b0);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd9) begin failures++; $display("FAIL mid_pre_len got=%0d exp=9", len_a); end
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    ioctl_upload = 1'b1;
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_byte(8'h99, 1'b0);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd9) begin failures++; $display("FAIL mid_len got=%0d exp=9", len_a); end
    checks++; if (act_a !== 1'b0) begin failures++; $display("FAIL mid_active got=%b exp=0", act_a); end
    ioctl_upload = 1'b0;
    start_block(1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h66, 1'b0);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd11) begin failures++; $display("FAIL resync_len got=%0d exp=11", len_a); end
    ioctl_upload = 1'b1;
    do_read(16'd9);
    checks++; if (din_a !== 8'hA5) begin failures++; $display("FAIL resync_addr9 got=%h exp=a5", din_a); end
    do_read(16'd10);
    checks++; if (din_a !== 8'h66) begin failures++; $display("FAIL resync_addr10 got=%h exp=66", din_a); end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_overflow();
    clear_pulse();
    @(negedge clk_sys);
    checks++; if (len_a !== 17'd0 || len_b !== 5'd0) begin failures++; $display("FAIL clear_pre got=%0d/%0d exp=0/0", len_a, len_b); end
    start_block(1);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(i * 13 + 7), 1'b0);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd21) begin failures++; $display("FAIL ovf_len_big got=%0d exp=21", len_a); end
    checks++; if (len_b !== 5'd16) begin failures++; $display("FAIL ovf_len_small got=%0d exp=16", len_b); end
    checks++; if (ovf_b !== 1'b1) begin failures++; $display("FAIL ovf_flag_small got=%b exp=1", ovf_b); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL ovf_flag_big got=%b exp=0", ovf_a); end
    do_read(16'd15);
    checks++; if (din_b !== 8'hBD) begin failures++; $display("FAIL ovf_small_addr15 got=%h exp=bd", din_b); end
    do_read(16'd20);
    checks++; if (din_a !== 8'hFE) begin failures++; $display("FAIL ovf_big_addr20 got=%h exp=fe", din_a); end
    clear_pulse();
    @(negedge clk_sys);
    checks++; if (len_a !== 17'd0 || len_b !== 5'd0) begin failures++; $display("FAIL clear_len got=%0d/%0d exp=0/0", len_a, len_b); end
    checks++; if (ovf_b !== 1'b0) begin failures++; $display("FAIL clear_overflow got=%b exp=0", ovf_b); end
    do_read(16'd0);
    checks++; if (din_a !== 8'h00) begin failures++; $display("FAIL clear_read got=%h exp=00", din_a); end
  endtask

  task automatic test_reset_midblock();
    start_block(1);
    send_byte(8'hA5, 1'b0);
    do_read(16'd0);
    checks++; if (din_a !== 8'hA5) begin failures++; $display("FAIL rst_pre_read got=%h exp=a5", din_a); end
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    checks++; if (act_a !== 1'b1 || len_a !== 17'd1) begin failures++; $display("FAIL rst_pre_state got=%b/%0d exp=1/1", act_a, len_a); end
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    checks++; if (len_a !== 17'd0) begin failures++; $display("FAIL rst_async_len got=%0d exp=0", len_a); end
    checks++; if (act_a !== 1'b0) begin failures++; $display("FAIL rst_async_active got=%b exp=0", act_a); end
    checks++; if (din_a !== 8'h00) begin failures++; $display("FAIL rst_async_din got=%h exp=00", din_a); end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    start_block(1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    repeat (4) @(negedge clk_sys);
    checks++; if (len_a !== 17'd2) begin failures++; $display("FAIL rst_new_len got=%0d exp=2", len_a); end
    ioctl_upload = 1'b1;
    do_read(16'd0);
    checks++; if (din_a !== 8'hA5) begin failures++; $display("FAIL rst_new_addr0 got=%h exp=a5", din_a); end
    do_read(16'd1);
    checks++; if (din_a !== 8'h5A) begin failures++; $display("FAIL rst_new_addr1 got=%h exp=5a", din_a); end
    ioctl_upload = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout_append();
    test_upload_read();
    test_glitch();
    test_upload_midblock();
    test_overflow();
    test_reset_midblock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
